// File: rtl/shared_instance_arbiter.sv
// Arbitrates one shared datapath among NUM_REQ requesters; grant registered 1 cycle after request, one IDLE bubble per release.
// Backpressure: res_ready_i=0 freezes grant, select and beat count; a stalled grant is held, never revoked.
module shared_instance_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int POLICY   = 0,
    parameter int MAX_HOLD = 8,
    localparam int IDX_W   = $clog2(NUM_REQ),
    localparam int HC_W    = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] last_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   res_sel_o,
    output logic               res_valid_o,
    input  logic               res_ready_i,
    output logic               busy_o
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    state_t             state, state_nxt;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic [IDX_W-1:0]   sel_nxt, rr_ptr, ptr_nxt, win;
    logic [HC_W-1:0]    hold_cnt, cnt_nxt;
    logic               sel_req, beat, hold_hit, rel;

    generate
        if (POLICY == 0) begin : g_round_robin
            logic [2*NUM_REQ-1:0] req_dbl;
            logic [NUM_REQ-1:0]   req_rot;
            logic [IDX_W:0]       off, sum;
            // Rotate so bit 0 is rr_ptr, take the lowest set bit, then rotate the index back.
            assign req_dbl = {req_i, req_i} >> rr_ptr;
            assign req_rot = req_dbl[NUM_REQ-1:0];
            always_comb begin
                off = '0;
                for (int i = NUM_REQ - 1; i >= 0; i--) begin
                    if (req_rot[i]) off = (IDX_W + 1)'(i);
                end
                sum = {1'b0, rr_ptr} + off;
                if (sum >= (IDX_W + 1)'(NUM_REQ)) sum = sum - (IDX_W + 1)'(NUM_REQ);
                win = sum[IDX_W-1:0];
            end
        end else if (POLICY == 1) begin : g_low_first
            always_comb begin
                win = '0;
                for (int i = NUM_REQ - 1; i >= 0; i--) begin
                    if (req_i[i]) win = IDX_W'(i);
                end
            end
        end else begin : g_high_first
            always_comb begin
                win = '0;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (req_i[i]) win = IDX_W'(i);
                end
            end
        end
    endgenerate

    assign busy_o      = (state == GRANT);
    assign sel_req     = req_i[res_sel_o];
    assign res_valid_o = busy_o & sel_req;
    assign beat        = res_valid_o & res_ready_i;
    assign hold_hit    = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    // A withdrawn request releases even though no beat can happen.
    assign rel         = ~sel_req | (beat & (last_i[res_sel_o] | hold_hit));

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt_o;
        sel_nxt   = res_sel_o;
        ptr_nxt   = rr_ptr;
        cnt_nxt   = hold_cnt;
        case (state)
            IDLE: begin
                if (|req_i) begin
                    state_nxt = GRANT;
                    gnt_nxt   = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
                    sel_nxt   = win;
                    cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (beat && hold_cnt != {HC_W{1'b1}}) cnt_nxt = hold_cnt + 1'b1;
                if (rel) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    if (POLICY == 0)
                        ptr_nxt = (res_sel_o == IDX_W'(NUM_REQ - 1)) ? '0 : res_sel_o + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt_o     <= '0;
            res_sel_o <= '0;
            rr_ptr    <= '0;
            hold_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            gnt_o     <= gnt_nxt;
            res_sel_o <= sel_nxt;
            rr_ptr    <= ptr_nxt;
            hold_cnt  <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_shared_instance_arbiter.sv
// Bench for shared_instance_arbiter: three policy variants share one stimulus stream and are tracked by a transaction-level model.
module tb_shared_instance_arbiter;

    localparam int N    = 4;
    localparam int MAXH = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] last = 4'b0000;
    logic       ready = 1'b0;

    logic [3:0] g0, g1, g2;
    logic [1:0] s0, s1, s2;
    logic       v0, v1, v2, b0, b1, b2;

    int passes = 0;
    int total  = 0;

    int m_busy [3];
    int m_sel  [3];
    int m_cnt  [3];
    int m_ptr  [3];

    always #5 clk = ~clk;

    shared_instance_arbiter #(.NUM_REQ(N), .POLICY(0), .MAX_HOLD(MAXH)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .last_i(last), .gnt_o(g0), .res_sel_o(s0),
        .res_valid_o(v0), .res_ready_i(ready), .busy_o(b0));
    shared_instance_arbiter #(.NUM_REQ(N), .POLICY(1), .MAX_HOLD(MAXH)) dut_lo (
        .clk(clk), .rst_n(rst_n), .req_i(req), .last_i(last), .gnt_o(g1), .res_sel_o(s1),
        .res_valid_o(v1), .res_ready_i(ready), .busy_o(b1));
    shared_instance_arbiter #(.NUM_REQ(N), .POLICY(2), .MAX_HOLD(MAXH)) dut_hi (
        .clk(clk), .rst_n(rst_n), .req_i(req), .last_i(last), .gnt_o(g2), .res_sel_o(s2),
        .res_valid_o(v2), .res_ready_i(ready), .busy_o(b2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int bitof(input logic [3:0] v, input int i);
        return (int'(v) >> i) & 1;
    endfunction

    // Policy 0 scans upward from the pointer with wrap; 1 takes lowest index; 2 takes highest.
    function automatic int pick(input int k, input logic [3:0] r);
        int j;
        if (k == 0) begin
            for (int i = 0; i < N; i++) begin
                j = (m_ptr[0] + i) % N;
                if (bitof(r, j) == 1) return j;
            end
        end else if (k == 1) begin
            for (int i = 0; i < N; i++) if (bitof(r, i) == 1) return i;
        end else begin
            for (int i = N - 1; i >= 0; i--) if (bitof(r, i) == 1) return i;
        end
        return 0;
    endfunction

    task automatic model_step();
        int has, bt, rl;
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                m_busy[k] = 0; m_sel[k] = 0; m_cnt[k] = 0; m_ptr[k] = 0;
            end else if (m_busy[k] == 0) begin
                if (req != 4'b0000) begin
                    m_sel[k]  = pick(k, req);
                    m_busy[k] = 1;
                    m_cnt[k]  = 0;
                end
            end else begin
                has = bitof(req, m_sel[k]);
                bt  = (has == 1 && ready) ? 1 : 0;
                rl  = (has == 0 || (bt == 1 && (bitof(last, m_sel[k]) == 1 || m_cnt[k] == MAXH - 1))) ? 1 : 0;
                if (bt == 1) m_cnt[k]++;
                if (rl == 1) begin
                    m_busy[k] = 0;
                    if (k == 0) m_ptr[0] = (m_sel[k] + 1) % N;
                end
            end
        end
    endtask

    task automatic check_one(input int k, input logic [3:0] g, input logic [1:0] s,
                             input logic v, input logic b);
        chk($sformatf("gnt%0d", k), g, (m_busy[k] == 1) ? (32'd1 << m_sel[k]) : 32'd0);
        chk($sformatf("sel%0d", k), s, m_sel[k]);
        chk($sformatf("busy%0d", k), b, m_busy[k]);
        chk($sformatf("valid%0d", k), v, (m_busy[k] == 1) ? bitof(req, m_sel[k]) : 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_one(0, g0, s0, v0, b0);
        check_one(1, g1, s1, v1, b1);
        check_one(2, g2, s2, v2, b2);
        chk("hold_cnt", dut.hold_cnt, m_cnt[0]);
        chk("rr_ptr", dut.rr_ptr, m_ptr[0]);
    endtask

    logic [3:0] rr_seq [8];

    initial begin
        rr_seq[0] = 4'b0000; rr_seq[1] = 4'b0010; rr_seq[2] = 4'b0000; rr_seq[3] = 4'b0100;
        rr_seq[4] = 4'b0000; rr_seq[5] = 4'b1000; rr_seq[6] = 4'b0000; rr_seq[7] = 4'b0001;

        // Reset with all requesters asserted
        rst_n = 1'b0; req = 4'b1111; last = 4'b1111; ready = 1'b1;
        tick(); tick();
        chk("rst_gnt", g0, 4'b0000);
        chk("rst_valid", v0, 1'b0);
        chk("rst_busy", b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("first_grant", g0, 4'b0001);

        // Round-robin rotation with one-beat transactions
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("rr_seq%0d", i), g0, rr_seq[i]);
        end

        // Lowest-index fixed priority never reaches req3
        req = 4'b1010;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("lo_never3", g1[3], 1'b0);
        end

        // Hold limit: eight beats, one bubble, then the other requester
        rst_n = 1'b0; tick();
        rst_n = 1'b1; req = 4'b0011; last = 4'b0000; ready = 1'b1;
        for (int i = 0; i < MAXH; i++) begin
            tick();
            chk($sformatf("hold_gnt%0d", i), g0, 4'b0001);
        end
        tick();
        chk("hold_bubble", g0, 4'b0000);
        tick();
        chk("hold_next", g0, 4'b0010);

        // Stall keeps grant and count frozen
        rst_n = 1'b0; tick();
        rst_n = 1'b1; req = 4'b0001; last = 4'b0001; ready = 1'b0;
        tick();
        chk("stall_grant", g0, 4'b0001);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_gnt", g0, 4'b0001);
            chk("stall_cnt", dut.hold_cnt, 4'd0);
        end
        ready = 1'b1;
        tick();
        chk("stall_release", g0, 4'b0000);

        // Reset during a grant of req2, then a withdraw while stalled
        rst_n = 1'b0; tick();
        rst_n = 1'b1; req = 4'b0100; ready = 1'b0;
        tick();
        chk("mid_grant2", g0, 4'b0100);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_gnt", g0, 4'b0000);
        chk("mid_rst_ptr", dut.rr_ptr, 2'd0);
        rst_n = 1'b1; req = 4'b0010;
        tick();
        chk("wd_grant", g0, 4'b0010);
        tick();
        chk("wd_hold", g0, 4'b0010);
        req = 4'b0000;
        tick();
        chk("wd_release", g0, 4'b0000);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            req   = 4'($urandom_range(0, 15));
            last  = 4'($urandom_range(0, 15));
            ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
